// File: rtl/audio_i2s_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : audio_i2s_rx
//  Description : I2S capture receiver for a codec in master mode. Synchronises
//                BCLK/ADCLRCK/ADCDAT into clk_clk, assembles left/right words
//                MSB-first, and queues stereo frames in a first-word-fall-
//                through FIFO read out through a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          rx_enable,
    input  logic                          audio_BCLK,
    input  logic                          audio_ADCLRCK,
    input  logic                          audio_ADCDAT,
    output logic [DATA_WIDTH-1:0]         sample_left,
    output logic [DATA_WIDTH-1:0]         sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          overflow_clear
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        SHIFT = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic bclk_s1, bclk_s2, bclk_s3;
    logic lrck_s1, lrck_s;
    logic dat_s1, dat_s;
    logic bclk_rise;

    // Two-stage synchronisers, with an extra BCLK stage for edge detection
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            bclk_s1 <= 1'b0;
            bclk_s2 <= 1'b0;
            bclk_s3 <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s  <= 1'b0;
            dat_s1  <= 1'b0;
            dat_s   <= 1'b0;
        end else begin
            bclk_s1 <= audio_BCLK;
            bclk_s2 <= bclk_s1;
            bclk_s3 <= bclk_s2;
            lrck_s1 <= audio_ADCLRCK;
            lrck_s  <= lrck_s1;
            dat_s1  <= audio_ADCDAT;
            dat_s   <= dat_s1;
        end
    end

    assign bclk_rise = bclk_s2 & ~bclk_s3;

    // ------------------------------------------------------------------
    // Word assembly state
    // ------------------------------------------------------------------
    state_t                  state, next_state;
    logic                    lr_prev;
    logic                    lr_edge;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [DATA_WIDTH-1:0]   cur_word;
    logic [CNT_W-1:0]        bit_cnt;
    logic [CNT_W-1:0]        bit_pos;
    logic                    channel;
    logic                    left_done;
    logic [DATA_WIDTH-1:0]   left_hold;
    logic                    word_done;
    logic                    enter_delay;
    logic                    first_bit;
    logic                    push;

    assign lr_edge = (lrck_s != lr_prev);
    assign bit_pos = LAST_BIT - bit_cnt;

    // Partial word with the current serial bit dropped into its MSB-first slot
    always_comb begin
        cur_word          = shreg;
        cur_word[bit_pos] = dat_s;
    end

    // FSM state register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state; the bit seen on an LRCK change is the I2S delay bit,
    // so every channel start enters DELAY and the following bit is the MSB
    always_comb begin
        next_state  = state;
        word_done   = 1'b0;
        enter_delay = 1'b0;
        first_bit   = 1'b0;
        if (!rx_enable) begin
            next_state = IDLE;
        end else if (bclk_rise) begin
            case (state)
                IDLE: begin
                    if (lr_prev && !lrck_s) begin
                        next_state  = DELAY;
                        enter_delay = 1'b1;
                    end
                end
                DELAY: begin
                    if (lr_edge) begin
                        enter_delay = 1'b1;
                    end else begin
                        next_state = SHIFT;
                        first_bit  = 1'b1;
                    end
                end
                SHIFT: begin
                    if (lr_edge || (bit_cnt == LAST_BIT)) begin
                        word_done = 1'b1;
                        if (lr_edge) begin
                            next_state  = DELAY;
                            enter_delay = 1'b1;
                        end else begin
                            next_state = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (lr_edge) begin
                        next_state  = DELAY;
                        enter_delay = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // A right word is only a frame when it closes a left word of the same frame
    assign push = word_done & channel & left_done;

    // Shift register, bit counter, channel tag and left-word holding register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            lr_prev   <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            channel   <= 1'b0;
            left_done <= 1'b0;
            left_hold <= '0;
        end else begin
            if (bclk_rise) begin
                lr_prev <= lrck_s;
            end
            if (!rx_enable) begin
                shreg     <= '0;
                bit_cnt   <= '0;
                left_done <= 1'b0;
            end else if (bclk_rise) begin
                if (word_done) begin
                    if (!channel) begin
                        left_hold <= cur_word;
                        left_done <= 1'b1;
                    end else begin
                        left_done <= 1'b0;
                    end
                end
                if (enter_delay) begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end else if (first_bit) begin
                    shreg   <= cur_word;
                    bit_cnt <= CNT_W'(1);
                    channel <= lr_prev;
                end else if ((state == SHIFT) && !word_done) begin
                    shreg   <= cur_word;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [LVL_W-1:0]        level;
    logic                    full;
    logic                    pop;
    logic                    push_ok;

    assign full    = (level == FULL_LVL);
    assign pop     = (level != '0) & sample_ready;
    assign push_ok = push & (~full | pop);

    // Storage, pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {left_hold, cur_word};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (overflow_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    assign sample_valid = (level != '0);
    assign sample_left  = mem[rd_ptr][2*DATA_WIDTH-1:DATA_WIDTH];
    assign sample_right = mem[rd_ptr][DATA_WIDTH-1:0];
    assign fifo_level   = level;

endmodule
`default_nettype wire
